timer_regs: RTL
===============

// Module: timer_regs
// PURPOSE
//   Multi-channel, byte-addressed register file for the timer peripheral.
//   Two ports: a bus port (CPU, 1-cycle registered read) and a peripheral port (timer core).
//   Adds per-channel layout, RO/RW/W1C byte classes and an error response.
//   Sits between the bus protocol adapter and the timer counter core.
// PARAMETERS
//   NCH        4               number of timer channels (1..16)
//   CH_BYTES   16              bytes per channel, fixed layout below
//   CH_ALLOW   16'h00FF        per-channel byte mask: bus may write (RW)
//   CH_W1C     16'h1000        per-channel byte mask: bus write-1-to-clear
//   SIZE       NCH*CH_BYTES    total bytes (derived)
//   AW         $clog2(SIZE)    address width (derived)
// PORTS
//   clk_i          in   1    clock
//   rst_ni         in   1    synchronous active-low reset
//   req_bus        in   1    bus access strobe, one cycle per access
//   write_bus      in   1    1=write, 0=read (qualified by req_bus)
//   be_bus         in   4    byte lane enables
//   addr_bus       in   AW   byte address; lane i targets byte addr_bus+i
//   data_i_bus     in   32   write data, lane i = bits [8i+:8]
//   data_o_bus     out  32   read data, valid with rvalid_bus, held after
//   rvalid_bus     out  1    1-cycle pulse, read data valid
//   err_bus        out  1    1-cycle pulse: enabled lane beyond SIZE-1 (read or write)
//   write_perip    in   1    peripheral write strobe
//   be_perip       in   4    peripheral byte enables
//   wraddr_perip   in   AW   peripheral write byte address
//   data_i_perip   in   32   peripheral write data
//   set_perip      in   NCH  per-channel STATUS bit0 (match) set pulse
//   rdaddr_perip   in   AW   peripheral read byte address
//   data_o_perip   out  32   combinational read of live bytes, disabled lanes 0
// BEHAVIOUR
//   Channel layout (offset in channel): 0-3 CTRL RW; 4-7 CMP RW; 8-11 COUNT RO(bus);
//     12 STATUS W1C(bus), set by perip; 13-15 reserved, read 0, writes dropped.
//   Reset (rst_ni=0 at edge): all bytes 0, data_o_bus=0, rvalid_bus=0, err_bus=0.
//     Reset mid-access: a read accepted in the reset cycle never produces rvalid_bus.
//   Bus write: on the edge where req_bus&write_bus, each lane with be_bus[i] and
//     in-range byte: RW byte <- data; W1C byte <- byte & ~data; RO/reserved unchanged.
//   Bus read: req_bus&~write_bus at edge N -> data_o_bus, rvalid_bus at N+1.
//     Disabled lanes read 0. Out-of-range lanes read 0 and pulse err_bus at N+1.
//     Out-of-range write lanes: ignored; err_bus pulses at N+1.
//   Peripheral write: any byte class writable except reserved; lane i -> byte wraddr_perip+i.
//   Collisions on the same byte, same edge: bus RW write beats perip write.
//     On STATUS, set_perip beats bus W1C (bit stays 1), then perip write applies
//     below set. Bus read concurrent with any write returns pre-edge value.
//   Address arithmetic is modulo nothing: addr+i >= SIZE is out of range, no wrap.
// CONFIGURATION
//   TIMER_REGS_SNAPSHOT_EN defined: a bus read enabling COUNT byte 8 latches
//     bytes 9-11 of that channel into a shadow at that edge; later bus reads of
//     9-11 return the shadow until the next byte-8 read. Shadow resets to 0.
//     Perip port always reads live bytes.
//   Not defined: no shadow; bus reads of 9-11 return live bytes.
// STRUCTURE
//   timer_pkg: byte offsets (OFF_CTRL=0, OFF_CMP=4, OFF_COUNT=8, OFF_STATUS=12),
//     CH_BYTES, default CH_ALLOW/CH_W1C masks, STATUS bit positions.
//   Sub-module timer_regs_chan: one channel's 16 bytes, merge/priority logic,
//     snapshot shadow; timer_regs does decode, lane routing, read regs, err.
// TESTING
//   1 reset -> read addr 0x00 be=F: data_o_bus=0, rvalid_bus one cycle after req.
//   2 bus write 0x04 data 0xA5A5_1234 be=F, read 0x04 -> 0xA5A5_1234 at N+1;
//     bus write 0x08 0xFFFF_FFFF -> COUNT unchanged (read 0).
//   3 unaligned: write addr 0x02 be=3 data 0x0000_BEEF -> bytes 2=0xEF,3=0xBE;
//     read addr 0x00 be=F -> 0xBEEF_0000.
//   4 set_perip[1] same edge as bus write 0x1C data 0x01 be=1 -> STATUS ch1 = 0x01;
//     next bus W1C alone -> 0x00.
//   5 NCH=4: read addr 0x3E be=F -> lanes 0-1 data, lanes 2-3 zero, err_bus=1 at N+1.
//   6 SNAPSHOT_EN: perip writes COUNT ch0=0x0000_00FF; bus read 0x08 be=1;
//     perip writes 0x0001_0000; bus read 0x09 be=7 -> 0x0000_0000 (shadow), not 0x0000_0100.

Source files
------------

// File: rtl/timer_regs_pkg.sv
// Shared constants for the timer register file: channel byte layout,
// default access masks, STATUS bit positions and a lane-select helper.
package timer_regs_pkg;

  localparam int CH_BYTES   = 16;

  // Byte offsets inside one channel
  localparam int OFF_CTRL   = 0;
  localparam int OFF_CMP    = 4;
  localparam int OFF_COUNT  = 8;
  localparam int OFF_STATUS = 12;

  // Default per-channel byte masks
  localparam logic [15:0] DEF_CH_ALLOW = 16'h00FF;  // bus read/write bytes
  localparam logic [15:0] DEF_CH_W1C   = 16'h1000;  // bus write-1-to-clear bytes
  localparam logic [15:0] CH_RESV      = 16'hE000;  // reserved bytes 13-15

  // STATUS byte bit positions
  localparam int STATUS_MATCH_BIT = 0;

  // Byte access class, used when reasoning about a byte offset
  typedef enum logic [1:0] {
    BC_RW  = 2'd0,
    BC_RO  = 2'd1,
    BC_W1C = 2'd2,
    BC_RSV = 2'd3
  } byte_class_e;

  // Pick the byte carried by the (at most one) selected lane
  function automatic logic [7:0] lane_pick(input logic [3:0] sel, input logic [31:0] data);
    return ({8{sel[0]}} & data[7:0])   | ({8{sel[1]}} & data[15:8]) |
           ({8{sel[2]}} & data[23:16]) | ({8{sel[3]}} & data[31:24]);
  endfunction

endpackage

// File: rtl/timer_regs_if.sv
// CPU-side bus port of the timer register file.
interface timer_regs_if #(
  parameter int AW = 6
) ();
  logic          req_bus;
  logic          write_bus;
  logic [3:0]    be_bus;
  logic [AW-1:0] addr_bus;
  logic [31:0]   data_i_bus;
  logic [31:0]   data_o_bus;
  logic          rvalid_bus;
  logic          err_bus;

  modport master (
    output req_bus, write_bus, be_bus, addr_bus, data_i_bus,
    input  data_o_bus, rvalid_bus, err_bus
  );

  modport slave (
    input  req_bus, write_bus, be_bus, addr_bus, data_i_bus,
    output data_o_bus, rvalid_bus, err_bus
  );
endinterface

// File: rtl/timer_regs_chan.sv
// One timer channel: 16 byte registers with bus/peripheral merge priority
// and the optional COUNT snapshot shadow (macro TIMER_REGS_SNAPSHOT_EN).
module timer_regs_chan
  import timer_regs_pkg::*;
#(
  parameter logic [15:0] CH_ALLOW = DEF_CH_ALLOW,
  parameter logic [15:0] CH_W1C   = DEF_CH_W1C
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [CH_BYTES-1:0]          bus_we,
  input  logic [CH_BYTES-1:0][7:0]     bus_wd,
  input  logic [CH_BYTES-1:0]          per_we,
  input  logic [CH_BYTES-1:0][7:0]     per_wd,
  input  logic                         set_match,
  input  logic                         snap,
  output logic [CH_BYTES-1:0][7:0]     live,
  output logic [CH_BYTES-1:0][7:0]     view
);

  // Reserved bytes never take writes from either port
  localparam logic [15:0] RW_MASK  = CH_ALLOW & ~CH_RESV;
  localparam logic [15:0] W1C_MASK = CH_W1C & ~CH_RESV;
  localparam logic [15:0] PER_MASK = ~CH_RESV;

  for (genvar gi = 0; gi < CH_BYTES; gi++) begin : g_byte
    logic [7:0] byte_reg;
    logic [7:0] byte_next;

    // Merge order: bus W1C, then peripheral write, then bus RW write; match set wins last
    always_comb begin
      byte_next = byte_reg;
      if (W1C_MASK[gi] && bus_we[gi]) byte_next = byte_reg & ~bus_wd[gi];
      if (PER_MASK[gi] && per_we[gi]) byte_next = per_wd[gi];
      if (RW_MASK[gi] && bus_we[gi])  byte_next = bus_wd[gi];
      if (gi == OFF_STATUS && set_match) byte_next[STATUS_MATCH_BIT] = 1'b1;
    end

    // Byte register
    always_ff @(posedge clk_i) begin
      if (!rst_ni) byte_reg <= '0;
      else         byte_reg <= byte_next;
    end

    assign live[gi] = byte_reg;
  end

`ifdef TIMER_REGS_SNAPSHOT_EN
  logic [2:0][7:0] shadow_reg;

  // Capture COUNT bytes 9-11 whenever the bus reads byte 8
  always_ff @(posedge clk_i) begin
    if (!rst_ni)   shadow_reg <= '0;
    else if (snap) shadow_reg <= live[OFF_COUNT+3:OFF_COUNT+1];
  end

  // Bus view: 9-11 come from the shadow unless this same access snaps (then live == captured)
  always_comb begin
    view = live;
    if (!snap) view[OFF_COUNT+3:OFF_COUNT+1] = shadow_reg;
  end
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign view        = live;
`endif

endmodule

// File: rtl/timer_regs.sv
// Timer register file top: bus/peripheral lane decode, per-byte write
// routing, registered bus read and error pulse.
// Optional feature macro: TIMER_REGS_SNAPSHOT_EN (COUNT snapshot shadow).
module timer_regs
  import timer_regs_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter logic [15:0] CH_ALLOW = DEF_CH_ALLOW,
  parameter logic [15:0] CH_W1C   = DEF_CH_W1C,
  localparam int         SIZE     = NCH * CH_BYTES,
  localparam int         AW       = $clog2(SIZE)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  timer_regs_if.slave    bus,
  input  logic           write_perip,
  input  logic [3:0]     be_perip,
  input  logic [AW-1:0]  wraddr_perip,
  input  logic [31:0]    data_i_perip,
  input  logic [NCH-1:0] set_perip,
  input  logic [AW-1:0]  rdaddr_perip,
  output logic [31:0]    data_o_perip
);

  logic                 bus_rd;
  logic                 bus_wr;
  logic [3:0][AW:0]     bus_lane;
  logic [3:0][AW:0]     wr_lane;
  logic [3:0][AW:0]     rd_lane;
  logic [3:0]           bus_ok;
  logic [3:0]           bus_oor;
  logic [3:0]           wr_ok;
  logic [3:0]           rd_ok;
  logic [31:0]          bus_rdata;
  logic [SIZE-1:0]      bus_we;
  logic [SIZE-1:0]      per_we;
  logic [SIZE-1:0][7:0] bus_wd;
  logic [SIZE-1:0][7:0] per_wd;
  logic [SIZE-1:0][7:0] live;
  logic [SIZE-1:0][7:0] view;
  logic [NCH-1:0]       snap;
  logic [31:0]          data_o_reg;
  logic                 rvalid_reg;
  logic                 err_reg;

  assign bus_rd = bus.req_bus & ~bus.write_bus;
  assign bus_wr = bus.req_bus &  bus.write_bus;

  // Lane i targets byte addr+i; one extra bit so addr+i never wraps
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign bus_lane[gi] = {1'b0, bus.addr_bus}  + (AW+1)'(gi);
    assign wr_lane[gi]  = {1'b0, wraddr_perip}  + (AW+1)'(gi);
    assign rd_lane[gi]  = {1'b0, rdaddr_perip}  + (AW+1)'(gi);
    assign bus_ok[gi]   = bus.be_bus[gi] &  (bus_lane[gi] < (AW+1)'(SIZE));
    assign bus_oor[gi]  = bus.be_bus[gi] & ~(bus_lane[gi] < (AW+1)'(SIZE));
    assign wr_ok[gi]    = be_perip[gi]   &  (wr_lane[gi]  < (AW+1)'(SIZE));
    assign rd_ok[gi]    = be_perip[gi]   &  (rd_lane[gi]  < (AW+1)'(SIZE));
    assign bus_rdata[8*gi +: 8]    = bus_ok[gi] ? view[bus_lane[gi][AW-1:0]] : 8'h00;
    assign data_o_perip[8*gi +: 8] = rd_ok[gi]  ? live[rd_lane[gi][AW-1:0]]  : 8'h00;
  end

  // Per-byte write enables/data: find which lane (if any) lands on this byte
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_byte
    logic [3:0] bhit;
    logic [3:0] phit;
    for (genvar gj = 0; gj < 4; gj++) begin : g_hit
      assign bhit[gj] = bus_ok[gj] & (bus_lane[gj][AW-1:0] == AW'(gi));
      assign phit[gj] = wr_ok[gj]  & (wr_lane[gj][AW-1:0]  == AW'(gi));
    end
    assign bus_we[gi] = bus_wr & (|bhit);
    assign per_we[gi] = write_perip & (|phit);
    assign bus_wd[gi] = lane_pick(bhit, bus.data_i_bus);
    assign per_wd[gi] = lane_pick(phit, data_i_perip);
    if ((gi % CH_BYTES) == OFF_COUNT) begin : g_snap
      assign snap[gi / CH_BYTES] = bus_rd & (|bhit);
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    timer_regs_chan #(
      .CH_ALLOW (CH_ALLOW),
      .CH_W1C   (CH_W1C)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .bus_we    (bus_we[gi*CH_BYTES +: CH_BYTES]),
      .bus_wd    (bus_wd[gi*CH_BYTES +: CH_BYTES]),
      .per_we    (per_we[gi*CH_BYTES +: CH_BYTES]),
      .per_wd    (per_wd[gi*CH_BYTES +: CH_BYTES]),
      .set_match (set_perip[gi]),
      .snap      (snap[gi]),
      .live      (live[gi*CH_BYTES +: CH_BYTES]),
      .view      (view[gi*CH_BYTES +: CH_BYTES])
    );
  end

  // Bus response: read data held between reads, rvalid/err single-cycle pulses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o_reg <= '0;
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      rvalid_reg <= bus_rd;
      err_reg    <= bus.req_bus & (|bus_oor);
      if (bus_rd) data_o_reg <= bus_rdata;
    end
  end

  assign bus.data_o_bus = data_o_reg;
  assign bus.rvalid_bus = rvalid_reg;
  assign bus.err_bus    = err_reg;

endmodule
